// File: rtl/aer_rank_decoder.sv
`default_nettype none
// ============================================================================
//  Module      : aer_rank_decoder
//  Description : Receiving end of an AER spike link. Completes the 4-phase
//                REQ/ACK handshake per spike, records each pixel's arrival
//                rank, flags duplicate / out-of-range IDs and raises DONE once
//                every pixel of the image has spiked.
//  Revision    : 1.0 - initial release
// ============================================================================
module aer_rank_decoder #(
  parameter int IMAGE_SIZE      = 256,
  parameter int IMAGE_SIZE_BITS = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [IMAGE_SIZE_BITS:0]   aerin_addr,
  input  logic                       aerin_req,
  output logic                       aerin_ack,
  input  logic                       start,
  input  logic [IMAGE_SIZE_BITS-1:0] rank_rd_addr,
  output logic [IMAGE_SIZE_BITS:0]   rank_rd_data,
  output logic [IMAGE_SIZE_BITS:0]   event_count,
  output logic                       done,
  output logic                       dup_err,
  output logic                       addr_err
);

  // Full-image count; also the "never spiked" read-back marker.
  localparam logic [IMAGE_SIZE_BITS:0] c_full = (IMAGE_SIZE_BITS+1)'(IMAGE_SIZE);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_WAIT_REQ = 3'd1,
    S_CAPTURE  = 3'd2,
    S_WAIT_LOW = 3'd3,
    S_DONE     = 3'd4
  } state_t;

  state_t                     r_state;
  state_t                     w_state_next;
  logic                       r_req_meta;
  logic                       r_req_s;
  logic                       r_ack;
  logic [IMAGE_SIZE-1:0]      r_valid;
  logic [IMAGE_SIZE_BITS-1:0] r_rank [IMAGE_SIZE];
  logic [IMAGE_SIZE_BITS:0]   r_event_count;
  logic                       r_dup_err;
  logic                       r_addr_err;

  logic                       w_capture;
  logic                       w_clear;
  logic                       w_addr_oob;
  logic [IMAGE_SIZE_BITS-1:0] w_idx;
  logic                       w_dup;
  logic                       w_write;

  assign w_capture  = (r_state == S_CAPTURE);
  // START is honoured only outside an active handshake.
  assign w_clear    = start && ((r_state == S_IDLE) || (r_state == S_WAIT_REQ) ||
                                (r_state == S_DONE));
  assign w_addr_oob = (aerin_addr >= c_full);
  assign w_idx      = aerin_addr[IMAGE_SIZE_BITS-1:0];
  assign w_dup      = r_valid[w_idx];
  assign w_write    = w_capture && !w_addr_oob && !w_dup && (r_event_count != c_full);

  // Two-flop synchronizer for the asynchronous request line.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_req_meta <= 1'b0;
      r_req_s    <= 1'b0;
    end else begin
      r_req_meta <= aerin_req;
      r_req_s    <= r_req_meta;
    end
  end

  // Handshake state register.
  always_ff @(posedge clk) begin
    if (!rst) r_state <= S_IDLE;
    else      r_state <= w_state_next;
  end

  // Next-state logic; CAPTURE always lasts exactly one cycle.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:     if (start) w_state_next = S_WAIT_REQ;
      S_WAIT_REQ: if (r_req_s) w_state_next = S_CAPTURE;
      S_CAPTURE:  w_state_next = S_WAIT_LOW;
      S_WAIT_LOW: if (!r_req_s)
                    w_state_next = (r_event_count == c_full) ? S_DONE : S_WAIT_REQ;
      S_DONE:     if (start) w_state_next = S_WAIT_REQ;
      default:    w_state_next = S_IDLE;
    endcase
  end

  // ACK is registered from the state, so it rises one edge after CAPTURE
  // is entered and falls one edge after WAIT_LOW is left.
  always_ff @(posedge clk) begin
    if (!rst) r_ack <= 1'b0;
    else      r_ack <= (r_state == S_CAPTURE) || (r_state == S_WAIT_LOW);
  end

  // Valid bits, event counter and sticky error flags.
  always_ff @(posedge clk) begin
    if (!rst || w_clear) begin
      r_valid       <= '0;
      r_event_count <= '0;
      r_dup_err     <= 1'b0;
      r_addr_err    <= 1'b0;
    end else if (w_capture) begin
      if (w_addr_oob) begin
        r_addr_err <= 1'b1;
      end else if (w_dup) begin
        r_dup_err <= 1'b1;
      end else if (w_write) begin
        r_valid[w_idx] <= 1'b1;
        r_event_count  <= r_event_count + 1'b1;
      end
    end
  end

  // Rank storage: not cleared by reset or START, validity lives in r_valid.
  always_ff @(posedge clk) begin
    if (rst && w_write) r_rank[w_idx] <= r_event_count[IMAGE_SIZE_BITS-1:0];
  end

  assign rank_rd_data = r_valid[rank_rd_addr] ? {1'b0, r_rank[rank_rd_addr]} : c_full;
  assign aerin_ack    = r_ack;
  assign event_count  = r_event_count;
  assign done         = (r_state == S_DONE);
  assign dup_err      = r_dup_err;
  assign addr_err     = r_addr_err;

endmodule
`default_nettype wire

// File: tb/tb_aer_rank_decoder.sv
`default_nettype none
// ============================================================================
//  Module      : tb_aer_rank_decoder
//  Description : Directed self-checking bench for aer_rank_decoder.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_aer_rank_decoder;

  logic       clk;
  logic       rst;
  logic [8:0] aerin_addr;
  logic       aerin_req;
  logic       aerin_ack;
  logic       start;
  logic [7:0] rank_rd_addr;
  logic [8:0] rank_rd_data;
  logic [8:0] event_count;
  logic       done;
  logic       dup_err;
  logic       addr_err;

  int checks;
  int errors;

  aer_rank_decoder #(.IMAGE_SIZE(256), .IMAGE_SIZE_BITS(8)) dut (
    .clk          (clk),
    .rst          (rst),
    .aerin_addr   (aerin_addr),
    .aerin_req    (aerin_req),
    .aerin_ack    (aerin_ack),
    .start        (start),
    .rank_rd_addr (rank_rd_addr),
    .rank_rd_data (rank_rd_data),
    .event_count  (event_count),
    .done         (done),
    .dup_err      (dup_err),
    .addr_err     (addr_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Raise REQ, count edges until ACK rises, drop REQ, count edges until ACK
  // falls. A count of -1 means the bound expired.
  task automatic do_event(input logic [8:0] a, output int rise_n, output int fall_n);
    rise_n = -1;
    fall_n = -1;
    @(negedge clk);
    aerin_addr = a;
    aerin_req  = 1'b1;
    for (int n = 1; n <= 20; n++) begin
      tick();
      if (aerin_ack) begin rise_n = n; break; end
    end
    @(negedge clk);
    aerin_req = 1'b0;
    for (int n = 1; n <= 20; n++) begin
      tick();
      if (!aerin_ack) begin fall_n = n; break; end
    end
  endtask

  task automatic read_rank(input logic [7:0] a);
    rank_rd_addr = a;
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    tick(); tick();
    @(negedge clk);
    rst = 1'b1;
    #1;
    checks++;
    if ({aerin_ack, done, dup_err, addr_err} !== 4'b0000 || event_count !== 9'd0) begin
      errors++;
      $display("FAIL reset_outputs: ack=%b done=%b dup=%b aerr=%b cnt=%0d, want all 0",
               aerin_ack, done, dup_err, addr_err, event_count);
    end
    for (int i = 0; i < 256; i++) begin
      read_rank(8'(i));
      checks++;
      if (rank_rd_data !== 9'd256) begin
        errors++;
        $display("FAIL reset_rank[%0d]: got %0d want 256", i, rank_rd_data);
      end
    end
    // REQ must be ignored while idle.
    @(negedge clk);
    aerin_addr = 9'd1;
    aerin_req  = 1'b1;
    for (int n = 0; n < 8; n++) tick();
    checks++;
    if (aerin_ack !== 1'b0) begin
      errors++;
      $display("FAIL idle_ignores_req: ack=%b want 0", aerin_ack);
    end
    @(negedge clk);
    aerin_req = 1'b0;
    for (int n = 0; n < 4; n++) tick();
  endtask

  task automatic test_single_event();
    int r, f;
    pulse_start();
    do_event(9'd5, r, f);
    checks++;
    if (r !== 4) begin errors++; $display("FAIL ack_rise_latency: got %0d want 4", r); end
    checks++;
    if (f !== 4) begin errors++; $display("FAIL ack_fall_latency: got %0d want 4", f); end
    read_rank(8'd5);
    checks++;
    if (rank_rd_data !== 9'd0 || event_count !== 9'd1 || done !== 1'b0) begin
      errors++;
      $display("FAIL single_event: rank5=%0d cnt=%0d done=%b want 0/1/0",
               rank_rd_data, event_count, done);
    end
  endtask

  task automatic test_full_image();
    int r, f;
    logic [7:0] p [256];
    int bad_hs;
    for (int i = 0; i < 256; i++) p[i] = 8'((i * 37 + 11) % 256);
    pulse_start();
    bad_hs = 0;
    for (int i = 0; i < 256; i++) begin
      do_event({1'b0, p[i]}, r, f);
      if (r != 4 || f != 4) bad_hs++;
    end
    checks++;
    if (bad_hs !== 0) begin
      errors++;
      $display("FAIL full_handshakes: %0d bad handshakes want 0", bad_hs);
    end
    checks++;
    if (done !== 1'b1 || event_count !== 9'd256 || dup_err !== 1'b0 || addr_err !== 1'b0) begin
      errors++;
      $display("FAIL full_status: done=%b cnt=%0d dup=%b aerr=%b want 1/256/0/0",
               done, event_count, dup_err, addr_err);
    end
    for (int i = 0; i < 256; i++) begin
      read_rank(p[i]);
      checks++;
      if (rank_rd_data !== 9'(i)) begin
        errors++;
        $display("FAIL full_rank[%0d]: got %0d want %0d", p[i], rank_rd_data, i);
      end
    end
    // 257th request must not be acknowledged.
    @(negedge clk);
    aerin_addr = 9'd0;
    aerin_req  = 1'b1;
    for (int n = 0; n < 10; n++) tick();
    checks++;
    if (aerin_ack !== 1'b0 || done !== 1'b1) begin
      errors++;
      $display("FAIL req_after_done: ack=%b done=%b want 0/1", aerin_ack, done);
    end
    @(negedge clk);
    aerin_req = 1'b0;
    for (int n = 0; n < 4; n++) tick();
  endtask

  task automatic test_duplicate();
    int r, f;
    pulse_start();
    checks++;
    if (done !== 1'b0 || event_count !== 9'd0) begin
      errors++;
      $display("FAIL start_clears: done=%b cnt=%0d want 0/0", done, event_count);
    end
    do_event(9'd7, r, f);
    do_event(9'd7, r, f);
    checks++;
    if (r !== 4 || f !== 4) begin
      errors++;
      $display("FAIL dup_handshake: rise=%0d fall=%0d want 4/4", r, f);
    end
    do_event(9'd9, r, f);
    checks++;
    if (dup_err !== 1'b1 || event_count !== 9'd2 || addr_err !== 1'b0) begin
      errors++;
      $display("FAIL dup_status: dup=%b cnt=%0d aerr=%b want 1/2/0", dup_err, event_count, addr_err);
    end
    read_rank(8'd7);
    checks++;
    if (rank_rd_data !== 9'd0) begin errors++; $display("FAIL dup_rank7: got %0d want 0", rank_rd_data); end
    read_rank(8'd9);
    checks++;
    if (rank_rd_data !== 9'd1) begin errors++; $display("FAIL dup_rank9: got %0d want 1", rank_rd_data); end
  endtask

  task automatic test_addr_error();
    int r, f;
    do_event(9'd300, r, f);
    checks++;
    if (r !== 4 || f !== 4) begin
      errors++;
      $display("FAIL oob_handshake: rise=%0d fall=%0d want 4/4", r, f);
    end
    checks++;
    if (addr_err !== 1'b1 || event_count !== 9'd2) begin
      errors++;
      $display("FAIL oob_status: aerr=%b cnt=%0d want 1/2", addr_err, event_count);
    end
    read_rank(8'd44);
    checks++;
    if (rank_rd_data !== 9'd256) begin errors++; $display("FAIL oob_no_write: rank44=%0d want 256", rank_rd_data); end
    pulse_start();
    read_rank(8'd7);
    checks++;
    if (addr_err !== 1'b0 || dup_err !== 1'b0 || event_count !== 9'd0 || rank_rd_data !== 9'd256) begin
      errors++;
      $display("FAIL start_clear_errs: aerr=%b dup=%b cnt=%0d rank7=%0d want 0/0/0/256",
               addr_err, dup_err, event_count, rank_rd_data);
    end
  endtask

  task automatic test_reset_mid_handshake();
    int r, f;
    int seen;
    @(negedge clk);
    aerin_addr = 9'd3;
    aerin_req  = 1'b1;
    seen = 0;
    for (int n = 0; n < 20; n++) begin
      tick();
      if (aerin_ack) begin seen = 1; break; end
    end
    checks++;
    if (seen !== 1) begin errors++; $display("FAIL mid_ack_rise: ack never rose"); end
    @(negedge clk);
    rst = 1'b0;
    tick();
    checks++;
    if (aerin_ack !== 1'b0 || event_count !== 9'd0) begin
      errors++;
      $display("FAIL mid_reset: ack=%b cnt=%0d want 0/0", aerin_ack, event_count);
    end
    @(negedge clk);
    rst = 1'b1;
    aerin_req = 1'b0;
    for (int n = 0; n < 4; n++) tick();
    pulse_start();
    do_event(9'd3, r, f);
    read_rank(8'd3);
    checks++;
    if (r !== 4 || f !== 4 || rank_rd_data !== 9'd0 || event_count !== 9'd1) begin
      errors++;
      $display("FAIL post_reset_event: rise=%0d fall=%0d rank3=%0d cnt=%0d want 4/4/0/1",
               r, f, rank_rd_data, event_count);
    end
  endtask

  initial begin
    checks       = 0;
    errors       = 0;
    rst          = 1'b0;
    start        = 1'b0;
    aerin_req    = 1'b0;
    aerin_addr   = 9'd0;
    rank_rd_addr = 8'd0;
    test_reset();
    test_single_event();
    test_full_image();
    test_duplicate();
    test_addr_error();
    test_reset_mid_handshake();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
